addsub_smag_ser: RTL
====================

Name: addsub_smag_ser

Overview:
Parametrised, digit-serial sign-magnitude adder/subtractor. This is the multi-cycle successor to the team's 4-bit add/magnitude-subtract unit.
- Add mode returns the sum plus carry-out.
- Subtract mode returns |a-b| plus a "negative" flag.
- Processes DIGIT bits per clock, with a start/ready/done handshake and an optional accumulate mode that reuses the previous result as operand a.
- Sits in the datapath between operand registers and the result bus, where area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; WIDTH >= DIGIT.
DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT.

Ports:
clk     input   1      rising-edge clock
rst_n   input   1      asynchronous active-low reset
start   input   1      request; accepted only when start & ready at a clk edge
op      input   1      1 = add, 0 = magnitude subtract
acc     input   1      1 = use held result register as operand a (a input ignored)
a       input   WIDTH  operand a (unsigned)
b       input   WIDTH  operand b (unsigned)
ready   output  1      high only in IDLE
done    output  1      one-cycle pulse; result/flag valid from this cycle on
result  output  WIDTH  add: (a+b) mod 2^WIDTH; sub: |a-b|
flag    output  1      add: carry-out; sub: 1 iff a < b

Behaviour:
- Reset (async assert, sync to clk on release): state=IDLE, ready=1, done=0, result=0, flag=0, internal digit counter=0.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On a clk edge with start=1:
    - Latch opA (a, or result if acc=1), b, op.
    - Clear carry/borrow.
    - Clear digit counter.
    - Go to CALC. ready falls.
  - start=0: stay in IDLE.
- CALC: one digit per edge, LSB digit first, for N edges.
  - Add: digit sum with carry chain.
  - Sub: opA + ~b + 1 digit-wise (carry-in 1 at digit 0).
  - After the Nth edge:
    - Add: flag = final carry; go to DONE.
    - Sub with final carry=1 (a >= b): flag=0; go to DONE.
    - Sub with final carry=0 (a < b): flag=1; go to FIXUP.
- FIXUP: two's-complement negate of the partial difference, one digit per edge (~d + 1, carry-in 1 at digit 0), for N edges, then go to DONE.
- DONE:
  - done=1 for exactly one cycle; result/flag are final.
  - Next edge goes to IDLE.
  - result/flag hold their values until the next operation's DONE or a reset.
- Intermediate digits must not be visible on result: result updates only on entry to DONE.
- Latency, measured from the accepting edge to the edge that asserts done:
  - N edges for add, or for sub with a >= b.
  - 2N edges for sub with a < b.
  - ready returns 1 one cycle after done.
- Boundary conditions:
  - start while ready=0 is ignored entirely; the operation in progress is unaffected.
  - a == b in sub mode: result=0, flag=0, no FIXUP.
  - Add overflow wraps; flag=1.
  - acc=1 with no prior op after reset uses opA = 0.
  - Sub in acc mode uses the magnitude only; the prior flag is not treated as a sign.
  - Operand inputs may change freely after the accepting edge.
  - Reset asserted mid-CALC/FIXUP aborts immediately to reset values; no done pulse.

Test Plan (WIDTH=16, DIGIT=4, N=4):
1. add a=0x0001 b=0x0002 -> done 4 edges after accept; result=0x0003, flag=0; ready high the following cycle.
2. sub a=0x0009 b=0x0008 -> done after 4 edges; result=0x0001, flag=0. Then sub a=0x0005 b=0x0007 -> done after 8 edges; result=0x0002, flag=1. Then sub a=b=0x1234 -> result=0, flag=0, 4 edges.
3. add a=0xFFFF b=0x0006 -> result=0x0005, flag=1. Then acc=1 add b=0x0010 -> result=0x0015, flag=0.
4. Issue sub 5,7 and pulse start with a=1 b=1 on edges 2 and 6 of the operation -> the extra starts are ignored, exactly one done pulse, result=0x0002, flag=1.
5. Start sub 0x0005,0x0007; assert rst_n=0 mid-FIXUP (edge 6) -> ready=1, done=0, result=0, flag=0 immediately; no done pulse after release. A fresh add 0x0001+0x0001 then yields 0x0002.
6. Parameter sweep with WIDTH=8/DIGIT=8 (N=1) and WIDTH=12/DIGIT=3 (N=4) -> random operands match a reference model; latency is N or 2N as specified.

Source files
------------

// File: rtl/addsub_smag_ser.sv
// Digit-serial sign-magnitude adder/subtractor: DIGIT bits per clock, LSB first,
// with a second serial pass that negates the difference when a < b.
module addsub_smag_ser #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_part;
    logic             r_carry;
    logic             r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_flag;

    logic                   w_fix;
    logic [DIGIT-1:0]       w_x;
    logic [DIGIT-1:0]       w_y;
    logic                   w_cin;
    logic [DIGIT:0]         w_sum;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_part_next;
    logic                   w_last;

    // One digit adder serves both passes: CALC adds opA + (b or ~b),
    // FIXUP adds ~partial + 0 with carry-in 1 to negate in place.
    always_comb begin
        w_fix       = (r_state == S_FIXUP);
        w_x         = w_fix ? ~r_part[DIGIT-1:0] : r_opa[DIGIT-1:0];
        w_y         = w_fix ? '0 : (r_op ? r_opb[DIGIT-1:0] : ~r_opb[DIGIT-1:0]);
        w_cin       = (r_cnt == '0) ? (w_fix | ~r_op) : r_carry;
        w_sum       = {1'b0, w_x} + {1'b0, w_y} + {{DIGIT{1'b0}}, w_cin};
        w_cat       = {w_sum[DIGIT-1:0], r_part};
        w_part_next = w_cat[WIDTH+DIGIT-1:DIGIT];
        w_last      = (r_cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_part   <= '0;
            r_carry  <= 1'b0;
            r_op     <= 1'b0;
            r_result <= '0;
            r_flag   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opa   <= acc ? r_result : a;
                        r_opb   <= b;
                        r_op    <= op;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_part  <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_part  <= w_part_next;
                    r_opa   <= r_opa >> DIGIT;
                    r_opb   <= r_opb >> DIGIT;
                    r_carry <= w_sum[DIGIT];
                    if (w_last) begin
                        r_cnt <= '0;
                        // Subtract without final carry means a < b: negate before publishing.
                        if (r_op || w_sum[DIGIT]) begin
                            r_result <= w_part_next;
                            r_flag   <= r_op & w_sum[DIGIT];
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_FIXUP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIXUP: begin
                    r_part  <= w_part_next;
                    r_carry <= w_sum[DIGIT];
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_result <= w_part_next;
                        r_flag   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign flag   = r_flag;
endmodule
